// File: rtl/wave_capture_pkg.sv
// Shared types and constants for the oscilloscope capture path.
// Also used by the display side to size its buffer reads.
package wave_capture_pkg;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } cap_state_e;

    localparam int          DISP_W      = 8;
    localparam logic [7:0]  OFFSET_FLIP = 8'h80;

    function automatic int samples_per_buf(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/wave_capture_if.sv
// Sample-stream input and ping-pong RAM write port of the capture controller.
// master: the capture block; slave: the codec/RAM/display side.
interface wave_capture_if
    import wave_capture_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int ADDR_W   = 8
);
    logic                new_sample_ready;
    logic [SAMPLE_W-1:0] new_sample_in;
    logic                wave_display_idle;
    logic [ADDR_W:0]     write_address;
    logic                write_enable;
    logic [DISP_W-1:0]   write_sample;
    logic                read_index;

    modport master (
        input  new_sample_ready,
        input  new_sample_in,
        input  wave_display_idle,
        output write_address,
        output write_enable,
        output write_sample,
        output read_index
    );

    modport slave (
        output new_sample_ready,
        output new_sample_in,
        output wave_display_idle,
        input  write_address,
        input  write_enable,
        input  write_sample,
        input  read_index
    );

endinterface

// File: rtl/wave_capture_zero_cross_detect.sv
// Positive zero-crossing detector: remembers the previous strobed sample and
// flags a strobe whose sign goes from negative to non-negative.
module zero_cross_detect
    import wave_capture_pkg::*;
#(
    parameter int SAMPLE_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                strobe_i,
    input  logic [SAMPLE_W-1:0] sample_i,
    output logic                crossing_o
);

    logic [SAMPLE_W-1:0] prev_sample_q;
    logic [SAMPLE_W-1:0] prev_sample_d;

    // Tracks on every strobe regardless of the capture state.
    always_comb begin
        prev_sample_d = prev_sample_q;
        if (strobe_i) begin
            prev_sample_d = sample_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_sample_q <= '0;
        end else begin
            prev_sample_q <= prev_sample_d;
        end
    end

    assign crossing_o = strobe_i & prev_sample_q[SAMPLE_W-1] & ~sample_i[SAMPLE_W-1];

endmodule

// File: rtl/wave_capture.sv
// Trigger-aligned capture of 256-sample frames into the half of a ping-pong
// RAM not being displayed; flips ownership once the display goes idle.
module wave_capture
    import wave_capture_pkg::*;
#(
    parameter int SAMPLE_W    = 16,
    parameter int ADDR_W      = 8,
    parameter int ARM_TIMEOUT = 1024
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    wave_capture_if.master cap_if
);

    localparam int              TO_W       = (ARM_TIMEOUT < 2) ? 1 : $clog2(ARM_TIMEOUT + 1);
    localparam bit              TO_EN      = (ARM_TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'((ARM_TIMEOUT > 0) ? ARM_TIMEOUT - 1 : 0);
    localparam logic [ADDR_W-1:0] COUNT_LAST = {ADDR_W{1'b1}};

    cap_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                read_index_q, read_index_d;
    logic                we_q, we_d;
    logic [ADDR_W:0]     addr_q, addr_d;
    logic [DISP_W-1:0]   data_q, data_d;

    logic                strobe;
    logic                crossing;
    logic                timeout_hit;
    logic [DISP_W-1:0]   sample_ob;

    assign strobe      = cap_if.new_sample_ready;
    assign sample_ob   = cap_if.new_sample_in[SAMPLE_W-1 -: DISP_W] ^ OFFSET_FLIP;
    assign timeout_hit = TO_EN && (to_cnt_q == TO_LAST);

    zero_cross_detect #(
        .SAMPLE_W (SAMPLE_W)
    ) u_zcd (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .strobe_i   (strobe),
        .sample_i   (cap_if.new_sample_in),
        .crossing_o (crossing)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        to_cnt_d     = to_cnt_q;
        read_index_d = read_index_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;

        case (state_q)
            ARMED: begin
                if (strobe) begin
                    if (crossing || timeout_hit) begin
                        we_d     = 1'b1;
                        addr_d   = {~read_index_q, {ADDR_W{1'b0}}};
                        data_d   = sample_ob;
                        count_d  = ADDR_W'(1);
                        to_cnt_d = '0;
                        state_d  = ACTIVE;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end

            ACTIVE: begin
                to_cnt_d = '0;
                if (strobe) begin
                    we_d    = 1'b1;
                    addr_d  = {~read_index_q, count_q};
                    data_d  = sample_ob;
                    count_d = count_q + 1'b1;
                    if (count_q == COUNT_LAST) begin
                        state_d = WAIT;
                    end
                end
            end

            WAIT: begin
                // A strobe landing on the flip edge is deliberately dropped.
                to_cnt_d = '0;
                if (cap_if.wave_display_idle) begin
                    read_index_d = ~read_index_q;
                    state_d      = ARMED;
                end
            end

            default: begin
                state_d = ARMED;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ARMED;
            count_q      <= '0;
            to_cnt_q     <= '0;
            read_index_q <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            to_cnt_q     <= to_cnt_d;
            read_index_q <= read_index_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
        end
    end

    assign cap_if.write_enable  = we_q;
    assign cap_if.write_address = addr_q;
    assign cap_if.write_sample  = data_q;
    assign cap_if.read_index    = read_index_q;

endmodule

// File: tb/tb_wave_capture.sv
// Directed bench for wave_capture: reset, trigger/fill, flip, timeout,
// flip-cycle crossing, back-to-back strobes and reset mid-capture.
module tb_wave_capture;
    import wave_capture_pkg::*;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    logic [8:0] wa_q[$];
    logic [7:0] wd_q[$];

    wave_capture_if #(.SAMPLE_W(16), .ADDR_W(8)) wif ();

    wave_capture #(
        .SAMPLE_W    (16),
        .ADDR_W      (8),
        .ARM_TIMEOUT (16)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .cap_if (wif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && wif.write_enable) begin
            wa_q.push_back(wif.write_address);
            wd_q.push_back(wif.write_sample);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] s);
        wif.new_sample_ready = 1'b1;
        wif.new_sample_in    = s;
        cyc(1);
        wif.new_sample_ready = 1'b0;
        cyc(1);
    endtask

    // Ramp sample k is k<<7: always positive, top byte k>>1.
    task automatic ramp(input int first, input int n);
        for (int k = first; k < first + n; k++) begin
            send(16'(k << 7));
        end
    endtask

    task automatic flip_pulse();
        wif.wave_display_idle = 1'b1;
        cyc(1);
        wif.wave_display_idle = 1'b0;
    endtask

    task automatic check_fill(input string tag, input logic [8:0] base, input logic [7:0] first_data);
        int bad;
        int n;
        bad = 0;
        n = (wa_q.size() < 256) ? wa_q.size() : 256;
        for (int k = 0; k < n; k++) begin
            logic [7:0] ed;
            ed = (k == 0) ? first_data : (8'(k >> 1) ^ 8'h80);
            if (wa_q[k] !== 9'(base + 9'(k)) || wd_q[k] !== ed) bad++;
        end
        chk({tag, "_count"}, 32'(wa_q.size()), 32'd256);
        chk({tag, "_bad"}, 32'(bad), 32'd0);
    endtask

    initial begin
        logic [8:0] a0;
        logic [7:0] d0;
        int         sz;

        rst_n                 = 1'b0;
        wif.new_sample_ready  = 1'b0;
        wif.new_sample_in     = '0;
        wif.wave_display_idle = 1'b0;

        // Reset
        cyc(3);
        chk("rst_we", 32'(wif.write_enable), 32'd0);
        chk("rst_addr", 32'(wif.write_address), 32'd0);
        rst_n = 1'b1;
        cyc(1);
        chk("rst_sample", 32'(wif.write_sample), 32'd0);
        chk("rst_ri", 32'(wif.read_index), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(ARMED));
        for (int i = 0; i < 5; i++) send(16'd100);
        chk("const_no_write", 32'(wa_q.size()), 32'd0);

        // Trigger and fill into half 1
        send(16'hFFFB);
        chk("neg_no_trig", 32'(wa_q.size()), 32'd0);
        send(16'h0007);
        ramp(1, 255);
        send(16'h0100);
        send(16'h0200);
        cyc(4);
        check_fill("fill1", 9'h100, 8'h80);
        chk("fill1_state", 32'(dut.state_q), 32'(WAIT));
        chk("fill1_ri", 32'(wif.read_index), 32'd0);

        // Flip after a long busy period
        wa_q.delete();
        wd_q.delete();
        cyc(50);
        chk("busy_ri", 32'(wif.read_index), 32'd0);
        flip_pulse();
        chk("flip_ri", 32'(wif.read_index), 32'd1);
        chk("flip_state", 32'(dut.state_q), 32'(ARMED));
        send(16'hFFFF);
        send(16'h1234);
        ramp(1, 255);
        cyc(2);
        check_fill("fill0", 9'h000, 8'h92);

        // Timeout trigger
        wa_q.delete();
        wd_q.delete();
        flip_pulse();
        chk("flip2_ri", 32'(wif.read_index), 32'd0);
        for (int i = 0; i < 15; i++) send(16'd1000);
        chk("to_15_no_write", 32'(wa_q.size()), 32'd0);
        send(16'd1000);
        sz = wa_q.size();
        a0 = (sz > 0) ? wa_q[0] : 9'h1FF;
        d0 = (sz > 0) ? wd_q[0] : 8'h00;
        chk("to_16_count", 32'(sz), 32'd1);
        chk("to_addr", 32'(a0), 32'h100);
        chk("to_data", 32'(d0), 32'h83);
        ramp(1, 255);
        cyc(2);
        chk("to_fill_count", 32'(wa_q.size()), 32'd256);
        chk("to_fill_state", 32'(dut.state_q), 32'(WAIT));

        // Crossing strobe on the flip edge is ignored
        wa_q.delete();
        wd_q.delete();
        send(16'hFF38);
        wif.wave_display_idle = 1'b1;
        wif.new_sample_ready  = 1'b1;
        wif.new_sample_in     = 16'h0007;
        cyc(1);
        wif.wave_display_idle = 1'b0;
        wif.new_sample_ready  = 1'b0;
        chk("sim_ri", 32'(wif.read_index), 32'd1);
        chk("sim_state", 32'(dut.state_q), 32'(ARMED));
        cyc(3);
        chk("sim_no_write", 32'(wa_q.size()), 32'd0);
        send(16'd50);
        chk("sim_pos_no_trig", 32'(wa_q.size()), 32'd0);
        send(16'hFFFD);
        send(16'h0500);
        sz = wa_q.size();
        a0 = (sz > 0) ? wa_q[0] : 9'h1FF;
        d0 = (sz > 0) ? wd_q[0] : 8'h00;
        chk("sim_trig_count", 32'(sz), 32'd1);
        chk("sim_trig_addr", 32'(a0), 32'h000);
        chk("sim_trig_data", 32'(d0), 32'h85);

        // Back-to-back strobes in adjacent cycles
        wif.new_sample_ready = 1'b1;
        wif.new_sample_in    = 16'h0200;
        cyc(1);
        wif.new_sample_in    = 16'h0300;
        cyc(1);
        wif.new_sample_ready = 1'b0;
        cyc(2);
        sz = wa_q.size();
        chk("b2b_count", 32'(sz), 32'd3);
        chk("b2b_addr1", 32'((sz > 1) ? wa_q[1] : 9'h1FF), 32'h001);
        chk("b2b_addr2", 32'((sz > 2) ? wa_q[2] : 9'h1FF), 32'h002);
        chk("b2b_data2", 32'((sz > 2) ? wd_q[2] : 8'h00), 32'h83);

        // Reset mid-capture after 40 writes
        ramp(3, 37);
        chk("mid_count", 32'(wa_q.size()), 32'd40);
        wa_q.delete();
        wd_q.delete();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ri", 32'(wif.read_index), 32'd0);
        chk("mid_rst_we", 32'(wif.write_enable), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        chk("mid_rst_state", 32'(dut.state_q), 32'(ARMED));
        for (int i = 0; i < 5; i++) send(16'd100);
        chk("mid_no_write", 32'(wa_q.size()), 32'd0);
        send(16'hFFFE);
        send(16'h0100);
        sz = wa_q.size();
        a0 = (sz > 0) ? wa_q[0] : 9'h000;
        d0 = (sz > 0) ? wd_q[0] : 8'h00;
        chk("mid_trig_count", 32'(sz), 32'd1);
        chk("mid_trig_addr", 32'(a0), 32'h100);
        chk("mid_trig_data", 32'(d0), 32'h81);
        send(16'h0200);
        chk("mid_next_addr", 32'((wa_q.size() > 1) ? wa_q[1] : 9'h000), 32'h101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wave_capture.md
# wave_capture

Capture controller for the oscilloscope display path. It watches the codec sample stream, arms on a positive zero-crossing and writes 256 consecutive samples into the inactive half of the 512-entry ping-pong sample RAM. It then waits for the display to go idle and flips `read_index`, so `wave_display` always reads a complete, trigger-aligned buffer. It sits between the codec/sample source and the sample RAM write port; `wave_display` owns the RAM read port.

## Interface
Parameters:
- `SAMPLE_W`, 16: width of the incoming signed sample.
- `ADDR_W`, 8: log2 of samples per buffer half; the RAM address is `ADDR_W+1` bits wide.
- `ARM_TIMEOUT`, 1024: number of strobes spent in ARMED without a crossing before a forced trigger; 0 disables the timeout.

Ports:
- `clk`  in  1  system clock; the only clock in the block.
- `reset`  in  1  asynchronous, active-low reset.
- `new_sample_ready`  in  1  one-cycle strobe; `new_sample_in` is valid in the same cycle.
- `new_sample_in`  in  SAMPLE_W  two's-complement audio sample.
- `wave_display_idle`  in  1  high while the display is not reading the RAM (vertical blank).
- `write_address`  out  ADDR_W+1  RAM write address; the MSB selects the half.
- `write_enable`  out  1  RAM write strobe.
- `write_sample`  out  8  offset-binary sample for the RAM.
- `read_index`  out  1  half currently owned by the display.

## Operation
- States: ARMED, ACTIVE, WAIT. Encoding is 2 bits.
- `prev_sample` is updated on every strobe, in every state.
- A crossing is a strobe with `prev_sample[SAMPLE_W-1]==1` and `new_sample_in[SAMPLE_W-1]==0`.

ARMED:
- On a crossing strobe, or on the strobe that brings the timeout count to ARM_TIMEOUT:
  - write the current sample at index 0;
  - set count to 1;
  - move to ACTIVE.
- Otherwise, increment the timeout count on each strobe.
- The timeout count clears on entry to ARMED.

ACTIVE:
- Each strobe writes at index `count`, then increments count.
- The strobe that writes index 2^ADDR_W−1 moves the block to WAIT.

WAIT:
- Strobes are ignored for writing; `prev_sample` still tracks.
- On any cycle with `wave_display_idle==1`: toggle `read_index` and move to ARMED. This is level-sensitive.

Addressing and data:
- Write address is `{~read_index, count[ADDR_W-1:0]}`, so writes never hit the half being displayed.
- Data conversion: `write_sample = new_sample_in[SAMPLE_W-1 -: 8] ^ 8'h80` (top byte, MSB inverted, giving offset binary).

## Timing
- Reset values:
  - state ARMED;
  - `read_index` 0;
  - `write_enable` 0;
  - `write_address` 0;
  - `write_sample` 0;
  - `prev_sample` 0, so the first sample can never trigger;
  - count 0 and timeout count 0.
- All outputs are registered. `write_enable`, `write_address` and `write_sample` become valid one cycle after the strobe and are held for exactly one cycle.
- `read_index` toggles on the clock edge that samples `wave_display_idle==1` in WAIT. ARMED is entered on that same edge, so a strobe in the next cycle can already trigger.
- A strobe in the same cycle as the WAIT→ARMED transition is evaluated as a WAIT strobe: no write and no trigger, but `prev_sample` updates.
- If `wave_display_idle` stays high across a whole capture, a second flip in the same blank interval is legal.
- Strobes arrive at most one every 2 cycles. Back-to-back strobes in adjacent cycles must still each produce exactly one write.
- Reset asserted mid-capture: all state returns to reset values immediately, and no write is issued after reset deasserts until a new trigger.

## Structure
- State encodings, and `SAMPLES_PER_BUF = 1<<ADDR_W`, go in the shared header `wave_defs.vh`, which `wave_display` also includes.
- One natural sub-module is `zero_cross_detect`. It contains the `prev_sample` register and the sign compare, and outputs a one-cycle `crossing` pulse aligned with the strobe.
- The FSM, counters and output registers stay in `wave_capture`.

## Test plan
- **Reset:** assert `reset=0` for 3 cycles, then release. Outputs read 0, state is ARMED, and no `write_enable` fires for a constant +100 stream.
- **Trigger and fill:**
  - Stimulus: strobes of −5, then +7, then a ramp.
  - Required: first write at address 0x100 with `write_sample` = (+7 top byte)^0x80; exactly 256 writes to addresses 0x100–0x1FF; then no writes.
- **Flip:**
  - Stimulus: in WAIT, hold `wave_display_idle=0` for 50 cycles, then pulse it for 1 cycle.
  - Required: `read_index` goes 0→1 on that edge, and the next capture writes addresses 0x000–0x0FF.
- **Timeout:** with ARM_TIMEOUT=16, feed 16 strobes of constant +1000. The 16th strobe triggers a write at index 0 of the inactive half.
- **Simultaneous flip and crossing:** drive a crossing strobe in the flip cycle. No write occurs, and the next negative→positive pair triggers normally.
- **Reset mid-capture:** after 40 writes, pulse reset. `read_index` returns to 0 and the write counter restarts at 0 on the next trigger.
